// File: rtl/plic_pkg.sv
// Shared PLIC definitions: claim FSM state encoding and width helpers.
package plic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StHold
  } claim_st_e;

  function automatic int unsigned pbits(input int unsigned priorities);
    return (priorities <= 2) ? 1 : $clog2(priorities);
  endfunction

  function automatic int unsigned idbits(input int unsigned sources);
    return $clog2(sources + 1);
  endfunction

endpackage

// File: rtl/plic_claim_ctrl_if.sv
// Claim/complete bus between a PLIC target port and its requester.
interface plic_claim_ctrl_if #(
  parameter int unsigned IDBITS = 4
) ();

  logic              claim_rd;
  logic              claim_rdy;
  logic              claim_vld;
  logic [IDBITS-1:0] claim_id;
  logic              complete_wr;
  logic [IDBITS-1:0] complete_id;

  modport master (
    output claim_rd, complete_wr, complete_id,
    input  claim_rdy, claim_vld, claim_id
  );

  modport slave (
    input  claim_rd, complete_wr, complete_id,
    output claim_rdy, claim_vld, claim_id
  );

endinterface

// File: rtl/plic_prio_max.sv
// Combinational highest-priority search; ties resolve to the lowest ID, ID 0 = none.
module plic_prio_max import plic_pkg::*; #(
  parameter int unsigned SOURCES = 8,
  parameter int unsigned PBITS   = 3,
  localparam int unsigned IDBITS = idbits(SOURCES)
) (
  input  logic [SOURCES-1:0]       req,
  input  logic [SOURCES*PBITS-1:0] prio,
  output logic [IDBITS-1:0]        best_id,
  output logic [PBITS-1:0]         best_pri
);

  // Strict compare keeps the earlier (lower) ID on ties; prio 0 never beats the zero seed.
  always_comb begin
    best_id  = '0;
    best_pri = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (req[i] && (prio[i*PBITS +: PBITS] > best_pri)) begin
        best_pri = prio[i*PBITS +: PBITS];
        best_id  = IDBITS'(i + 1);
      end
    end
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// PLIC per-target claim/complete controller. Optional in-service tracking under
// PLIC_INSERVICE_CHK_EN (completes for IDs not currently claimed are dropped).
module plic_claim_ctrl import plic_pkg::*; #(
  parameter int unsigned SOURCES    = 8,
  parameter int unsigned PRIORITIES = 8,
  localparam int unsigned PBITS     = pbits(PRIORITIES),
  localparam int unsigned IDBITS    = idbits(SOURCES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SOURCES-1:0]       ip,
  input  logic [SOURCES-1:0]       ie,
  input  logic [SOURCES*PBITS-1:0] prio,
  input  logic [PBITS-1:0]         threshold,
  output logic                     eip,
  output logic [SOURCES-1:0]       claim,
  output logic [SOURCES-1:0]       complete,
  plic_claim_ctrl_if.slave         bus
);

  claim_st_e          state_q;
  logic               claim_vld_q;
  logic               eip_q;
  logic [IDBITS-1:0]  best_id_q;
  logic [PBITS-1:0]   best_pri_q;
  logic [SOURCES-1:0] complete_q;

  logic [IDBITS-1:0]  best_id_c;
  logic [PBITS-1:0]   best_pri_c;
  logic               claim_hit;
  logic [SOURCES-1:0] cmpl_oh;
  logic [SOURCES-1:0] cmpl_fwd;

  plic_prio_max #(
    .SOURCES (SOURCES),
    .PBITS   (PBITS)
  ) u_prio_max (
    .req      (ip & ie),
    .prio     (prio),
    .best_id  (best_id_c),
    .best_pri (best_pri_c)
  );

  // eip_q holds best_pri > threshold as sampled with the accepted claim.
  assign claim_hit = claim_vld_q && eip_q && (best_pri_q != '0);

  always_comb begin
    claim   = '0;
    cmpl_oh = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      claim[i]   = claim_hit && (best_id_q == IDBITS'(i + 1));
      cmpl_oh[i] = bus.complete_wr && (bus.complete_id == IDBITS'(i + 1));
    end
  end

`ifdef PLIC_INSERVICE_CHK_EN
  logic [SOURCES-1:0] inservice_q;

  assign cmpl_fwd = cmpl_oh & inservice_q;

  // Set after clear so a same-cycle claim of the completed ID wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inservice_q <= '0;
    end else begin
      inservice_q <= (inservice_q & ~cmpl_oh) | claim;
    end
  end
`else
  assign cmpl_fwd = cmpl_oh;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      claim_vld_q <= 1'b0;
      eip_q       <= 1'b0;
      best_id_q   <= '0;
      best_pri_q  <= '0;
      complete_q  <= '0;
    end else begin
      best_id_q   <= best_id_c;
      best_pri_q  <= best_pri_c;
      eip_q       <= (best_pri_c > threshold);
      complete_q  <= cmpl_fwd;
      claim_vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.claim_rd) begin
            state_q     <= StResp;
            claim_vld_q <= 1'b1;
          end
        end
        StResp:  state_q <= StHold;
        StHold:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eip           = eip_q;
  assign complete      = complete_q;
  assign bus.claim_rdy = (state_q == StIdle);
  assign bus.claim_vld = claim_vld_q;
  assign bus.claim_id  = claim_hit ? best_id_q : '0;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed bench for plic_claim_ctrl (SOURCES=8, PRIORITIES=8).
module tb_plic_claim_ctrl;

  localparam int unsigned SOURCES    = 8;
  localparam int unsigned PRIORITIES = 8;
  localparam int unsigned PBITS      = 3;
  localparam int unsigned IDBITS     = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [SOURCES-1:0]       ip;
  logic [SOURCES-1:0]       ie;
  logic [SOURCES*PBITS-1:0] prio;
  logic [PBITS-1:0]         threshold;
  logic                     eip;
  logic [SOURCES-1:0]       claim;
  logic [SOURCES-1:0]       complete;

  plic_claim_ctrl_if #(.IDBITS(IDBITS)) bus ();

  plic_claim_ctrl #(
    .SOURCES    (SOURCES),
    .PRIORITIES (PRIORITIES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ip        (ip),
    .ie        (ie),
    .prio      (prio),
    .threshold (threshold),
    .eip       (eip),
    .claim     (claim),
    .complete  (complete),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_vld;
  int          first_cyc;
  int          second_cyc;
  logic [31:0] id0;
  logic [31:0] id1;
  logic [31:0] claim0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic complete_pulse(input logic [IDBITS-1:0] id);
    bus.complete_wr = 1'b1;
    bus.complete_id = id;
    step();
    bus.complete_wr = 1'b0;
    bus.complete_id = '0;
  endtask

  initial begin
    rst_n           = 1'b0;
    ip              = '0;
    ie              = '0;
    prio            = '0;
    threshold       = '0;
    bus.claim_rd    = 1'b0;
    bus.complete_wr = 1'b0;
    bus.complete_id = '0;
    step();
    step();
    check("rst_eip",       32'(eip),           32'd0);
    check("rst_claim_vld", 32'(bus.claim_vld), 32'd0);
    check("rst_claim_id",  32'(bus.claim_id),  32'd0);
    check("rst_claim",     32'(claim),         32'd0);
    check("rst_complete",  32'(complete),      32'd0);
    check("rst_claim_rdy", 32'(bus.claim_rdy), 32'd1);

    // IDs 3 and 5 tie at priority 5: lowest ID wins.
    rst_n     = 1'b1;
    ie        = 8'hFF;
    ip        = 8'b0001_0100;
    prio[2*PBITS +: PBITS] = 3'd5;
    prio[4*PBITS +: PBITS] = 3'd5;
    threshold = 3'd2;
    step();
    check("tie_eip", 32'(eip), 32'd1);
    bus.claim_rd = 1'b1;
    step();
    bus.claim_rd = 1'b0;
    check("tie_vld",   32'(bus.claim_vld), 32'd1);
    check("tie_id",    32'(bus.claim_id),  32'd3);
    check("tie_claim", 32'(claim),         32'h04);
    check("tie_rdy",   32'(bus.claim_rdy), 32'd0);
    ip = ip & ~claim;
    step();
    check("hold_vld",   32'(bus.claim_vld), 32'd0);
    check("hold_claim", 32'(claim),         32'd0);
    step();
    check("idle_rdy", 32'(bus.claim_rdy), 32'd1);

    // Priority equal to threshold does not qualify.
    ip        = 8'b0000_0010;
    prio      = '0;
    prio[1*PBITS +: PBITS] = 3'd2;
    threshold = 3'd2;
    step();
    check("thr_eip", 32'(eip), 32'd0);
    bus.claim_rd = 1'b1;
    step();
    bus.claim_rd = 1'b0;
    check("thr_vld",   32'(bus.claim_vld), 32'd1);
    check("thr_id",    32'(bus.claim_id),  32'd0);
    check("thr_claim", 32'(claim),         32'd0);
    step();
    step();

    // claim_rd held for 6 cycles, IDs 7 (prio 6) and 4 (prio 3) pending.
    ip        = 8'b0100_1000;
    prio      = '0;
    prio[3*PBITS +: PBITS] = 3'd3;
    prio[6*PBITS +: PBITS] = 3'd6;
    threshold = 3'd1;
    step();
    n_vld      = 0;
    first_cyc  = -1;
    second_cyc = -1;
    id0        = '0;
    id1        = '0;
    claim0     = '0;
    bus.claim_rd = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) bus.claim_rd = 1'b0;
      step();
      if (bus.claim_vld) begin
        if (n_vld == 0) begin
          first_cyc = c;
          id0       = 32'(bus.claim_id);
          claim0    = 32'(claim);
        end else begin
          second_cyc = c;
          id1        = 32'(bus.claim_id);
        end
        n_vld++;
        ip = ip & ~claim;
      end
    end
    check("burst_count",  32'(n_vld),                  32'd2);
    check("burst_gap",    32'(second_cyc - first_cyc), 32'd3);
    check("burst_id0",    id0,                         32'd7);
    check("burst_claim0", claim0,                      32'h40);
    check("burst_id1",    id1,                         32'd4);

    // Out-of-range complete ignored; complete of claimed ID 4 forwarded.
    complete_pulse(4'd9);
    check("cmpl9", 32'(complete), 32'd0);
    step();
    check("cmpl9_late", 32'(complete), 32'd0);
    complete_pulse(4'd4);
    check("cmpl4", 32'(complete), 32'h08);
    step();
    check("cmpl4_end", 32'(complete), 32'd0);

    // Complete for never-claimed ID 6.
    complete_pulse(4'd6);
`ifdef PLIC_INSERVICE_CHK_EN
    check("cmpl6_unclaimed", 32'(complete), 32'd0);
`else
    check("cmpl6_unclaimed", 32'(complete), 32'h20);
`endif
    step();

    // Reset while in RESP aborts the claim.
    ip        = 8'h01;
    prio      = '0;
    prio[0 +: PBITS] = 3'd4;
    threshold = 3'd0;
    step();
    check("rr_eip", 32'(eip), 32'd1);
    bus.claim_rd = 1'b1;
    step();
    bus.claim_rd = 1'b0;
    check("rr_vld",   32'(bus.claim_vld), 32'd1);
    check("rr_claim", 32'(claim),         32'h01);
    rst_n = 1'b0;
    step();
    check("rr_post_vld",   32'(bus.claim_vld), 32'd0);
    check("rr_post_claim", 32'(claim),         32'd0);
    check("rr_post_rdy",   32'(bus.claim_rdy), 32'd1);
    check("rr_post_eip",   32'(eip),           32'd0);
    rst_n = 1'b1;
    step();
    check("rr_recover_eip", 32'(eip), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_claim_ctrl.md
PLIC_CLAIM_CTRL -- requirements
Module: plic_claim_ctrl

Interface
REQ-001 SHALL have parameter SOURCES, default 8, giving the number of interrupt sources; source i (bit i) carries ID i+1, and ID 0 means "no interrupt".
REQ-002 SHALL have parameter PRIORITIES, default 8, giving the number of priority levels; PBITS = clog2(PRIORITIES), IDBITS = clog2(SOURCES+1).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port ip, input, SOURCES bits: gateway interrupt-pending bits.
REQ-007 SHALL have port ie, input, SOURCES bits: per-source enables for this target.
REQ-008 SHALL have port prio, input, SOURCES*PBITS bits: packed source priorities, source i at [i*PBITS +: PBITS].
REQ-009 SHALL have port threshold, input, PBITS bits: target priority threshold.
REQ-010 SHALL have port eip, output, 1 bit: external interrupt pending to the target.
REQ-011 SHALL have port claim_rd, input, 1 bit: claim-read strobe.
REQ-012 SHALL have port claim_rdy, output, 1 bit: claim-read accepted when high.
REQ-013 SHALL have port claim_vld, output, 1 bit: claim response strobe.
REQ-014 SHALL have port claim_id, output, IDBITS bits: claimed ID.
REQ-015 SHALL have port complete_wr, input, 1 bit: completion-write strobe.
REQ-016 SHALL have port complete_id, input, IDBITS bits: completed ID.
REQ-017 SHALL have port claim, output, SOURCES bits: one-hot strobe to the gateways.
REQ-018 SHALL have port complete, output, SOURCES bits: one-hot strobe to the gateways.

Function
REQ-019 SHALL register best_id/best_pri each cycle, taken over sources with ip&ie set and prio>0: highest priority wins; on a priority tie the lowest ID wins; if no source qualifies, best_id=0.
REQ-020 SHALL register eip = (best_pri > threshold), computed from the same-cycle inputs, giving one-cycle latency from ip/ie/prio/threshold to eip.
REQ-021 SHALL implement an FSM with states IDLE, RESP and HOLD; claim_rdy is high only in IDLE.
REQ-022 SHALL, for claim_rd in IDLE at cycle t, move to RESP; in cycle t+1, pulse claim_vld with claim_id = best_id as registered at t.
REQ-023 SHALL, in cycle t+1, pulse claim[claim_id-1] only if claim_id≠0 and best_pri>threshold; otherwise claim_id=0 and no claim strobe is issued.
REQ-024 SHALL go RESP→HOLD→IDLE unconditionally, so the next claim is accepted no earlier than t+3, which covers the gateway's ip clearing.
REQ-025 SHALL ignore claim_rd in RESP and HOLD: no response, no state effect.
REQ-026 SHALL, for complete_wr with 1≤complete_id≤SOURCES, pulse complete[complete_id-1] exactly one cycle later, subject to REQ-033.
REQ-027 SHALL ignore complete_wr with complete_id=0 or complete_id>SOURCES.
REQ-028 SHALL process complete_wr in any FSM state, independent of and concurrent with a claim.
REQ-029 SHALL hold claim, complete and claim_vld low on every cycle in which they are not pulsed.

Reset
REQ-030 SHALL, while rst_n is low at a clock edge, set: FSM=IDLE; eip, claim_vld, claim, complete = 0; claim_id=0; best_id/best_pri=0; in-service bitmap=0.
REQ-031 SHALL, when reset is asserted mid-claim (RESP/HOLD), abort the claim with no strobe emitted in the following cycle.

Configuration
REQ-032 SHALL compile an in-service bitmap under macro PLIC_INSERVICE_CHK_EN.
REQ-033 SHALL, with PLIC_INSERVICE_CHK_EN defined: set the bit on an issued claim strobe; clear the bit on complete; forward complete only if the bit is set, otherwise drop it; when a claim and a complete for the same ID occur in the same cycle, the set wins.
REQ-034 SHALL, without PLIC_INSERVICE_CHK_EN: contain no bitmap, and forward every in-range complete.

Structure
REQ-035 SHALL take the FSM state encoding and the IDBITS/PBITS helper functions from shared package plic_pkg.
REQ-036 SHALL place the priority/ID maximum search in combinational sub-module plic_prio_max (SOURCES, PBITS parameters), reusable by other targets.

Verification
REQ-037 SHALL cover: ip=0b00010100, prio3=5, prio5=5, threshold=2, claim_rd → claim_id=3, claim=0b00000100 at t+1.
REQ-038 SHALL cover: single source ID 2 with prio=2, threshold=2 → eip=0; claim_rd → claim_id=0, no claim strobe.
REQ-039 SHALL cover: claim_rd held high for 6 cycles with two sources pending → exactly two claim_vld pulses, 3 cycles apart, with distinct IDs.
REQ-040 SHALL cover: complete_wr with id=9 (SOURCES=8) → no complete strobe; with id=4 after claiming 4 → complete=0b00001000 one cycle later.
REQ-041 SHALL cover, with PLIC_INSERVICE_CHK_EN: complete for unclaimed ID 6 → dropped; the same stimulus without the macro → forwarded.
REQ-042 SHALL cover: rst_n low during RESP → claim_vld=0, claim=0 next cycle, FSM=IDLE, eip=0.
